// File: rtl/vector_checker_pkg.sv
// Shared types for the exhaustive vector checker.
package vector_checker_pkg;

    // Run-control states: idle, holding a vector, sampling the response, finished.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } vc_state_t;

    // Counter width needed to count 0 .. settle-1 (never narrower than one bit).
    function automatic int settle_cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/vector_checker.sv
// Walks every input vector of a small combinational DUT in ascending order,
// holds each one for SETTLE cycles, samples the response, and compares it with
// a golden truth table. Reports an error count and the first failing vector.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int                    N_IN     = 3,
    parameter logic [2**N_IN-1:0]    EXPECTED = 8'h31,
    parameter int                    SETTLE   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic              resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail,
    output logic              first_fail_valid
);

    localparam int                CNT_W    = settle_cnt_width(SETTLE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]   VEC_LAST = {N_IN{1'b1}};

    vc_state_t          state_q, state_d;
    logic [N_IN-1:0]    stim_q, stim_d;
    logic [N_IN:0]      err_q, err_d;
    logic [N_IN-1:0]    ff_q, ff_d;
    logic               ffv_q, ffv_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mismatch;

    // The response disagrees with the golden bit for the vector being driven.
    assign mismatch = (resp != EXPECTED[stim_q]);

    // State and result registers; reset aborts any run and discards its results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            stim_q  <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start accepted only when idle/done, settle, then sample.
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    stim_d  = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    // Cannot wrap: at most 2**N_IN mismatches fit in N_IN+1 bits.
                    err_d = err_q + (N_IN+1)'(1);
                    if (!ffv_q) begin
                        ff_d  = stim_q;
                        ffv_d = 1'b1;
                    end
                end
                if (stim_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    stim_d  = stim_q + N_IN'(1);
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stim             = stim_q;
    assign err_count        = err_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;
    assign busy             = (state_q == WAIT) || (state_q == CHECK);
    assign done             = (state_q == DONE);
    assign pass             = done && (err_q == '0);

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: drives a sillyfunction model or a random/stuck
// response table and checks results against a truth-table reference model.
module tb_vector_checker;

    localparam logic [7:0] GOLDEN = 8'h31;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic use_silly = 1'b1;
    logic [7:0] tt = 8'h00;
    logic sel = 1'b0;

    logic [2:0] stim_a, stim_b, ff_a, ff_b;
    logic [3:0] err_a, err_b;
    logic resp_a, resp_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural sillyfunction: y = ~b~c + a~b with {a,b,c} = vector.
    function automatic logic silly(input logic [2:0] v);
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    assign resp_a = use_silly ? silly(stim_a) : tt[stim_a];
    assign resp_b = use_silly ? silly(stim_b) : tt[stim_b];

    vector_checker #(.N_IN(3), .EXPECTED(8'h31), .SETTLE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .stim(stim_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail(ff_a), .first_fail_valid(ffv_a));

    vector_checker #(.N_IN(3), .EXPECTED(8'h31), .SETTLE(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .stim(stim_b), .resp(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail(ff_b), .first_fail_valid(ffv_b));

    // Observation of the instance under test.
    wire [2:0] o_stim = sel ? stim_b : stim_a;
    wire [3:0] o_err  = sel ? err_b  : err_a;
    wire [2:0] o_ff   = sel ? ff_b   : ff_a;
    wire       o_ffv  = sel ? ffv_b  : ffv_a;
    wire       o_busy = sel ? busy_b : busy_a;
    wire       o_done = sel ? done_b : done_a;
    wire       o_pass = sel ? pass_b : pass_a;

    // Reference model: response the DUT sees for vector v.
    function automatic logic model_resp(input int v);
        logic [2:0] vv;
        vv = 3'(v);
        return use_silly ? silly(vv) : tt[vv];
    endfunction

    function automatic int model_errs();
        int n = 0;
        for (int v = 0; v < 8; v++) if (model_resp(v) != GOLDEN[v]) n++;
        return n;
    endfunction

    function automatic int model_first();
        for (int v = 0; v < 8; v++) if (model_resp(v) != GOLDEN[v]) return v;
        return 0;
    endfunction

    // Drives one run on the selected instance and records observations only.
    task automatic run(input int pulse_at, output int done_cycle, output bit seq_ok,
                       output logic [3:0] c1_err, output logic c1_ffv, output logic c1_done);
        int s;
        s = sel ? 3 : 1;
        seq_ok = 1'b1;
        done_cycle = -1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        c1_err = o_err; c1_ffv = o_ffv; c1_done = o_done;
        for (int c = 1; c <= 200; c++) begin
            if (o_done === 1'b1) begin
                done_cycle = c;
                if (o_stim !== 3'd7 || o_busy !== 1'b0) seq_ok = 1'b0;
                break;
            end
            if (o_busy !== 1'b1 || o_stim !== 3'((c - 1) / (s + 1))) seq_ok = 1'b0;
            if (c == pulse_at) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
        end
        $display("run sel=%0d tt=%h silly=%0d done_cycle=%0d err=%0d ff=%0d ffv=%0d pass=%0d",
                 sel, tt, use_silly, done_cycle, o_err, o_ff, o_ffv, o_pass);
    endtask

    // Checks a finished run against the model and the expected completion cycle.
    int dc; bit sq; logic [3:0] e1; logic f1, d1;

    task automatic test_reset();
        checks++;
        if ({stim_a, busy_a, done_a, pass_a, err_a, ff_a, ffv_a} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {stim_a, busy_a, done_a, pass_a, err_a, ff_a, ffv_a});
        end
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL idle_without_start got busy=%b done=%b want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_correct();
        sel = 1'b0; use_silly = 1'b1;
        run(0, dc, sq, e1, f1, d1);
        checks++;
        if (dc !== 17) begin failures++; $display("FAIL correct_done_cycle got=%0d want=17", dc); end
        checks++;
        if (sq !== 1'b1) begin failures++; $display("FAIL correct_stim_sequence got=%0d want=1", sq); end
        checks++;
        if (o_pass !== 1'b1 || o_err !== 4'd0 || o_ffv !== 1'b0) begin
            failures++; $display("FAIL correct_result got pass=%b err=%0d ffv=%b want 1 0 0", o_pass, o_err, o_ffv);
        end
    endtask

    task automatic test_stuck(input logic val, input string nm);
        sel = 1'b0; use_silly = 1'b0; tt = {8{val}};
        run(0, dc, sq, e1, f1, d1);
        checks++;
        if (o_err !== 4'(model_errs())) begin
            failures++; $display("FAIL %s_err_count got=%0d want=%0d", nm, o_err, model_errs());
        end
        checks++;
        if (o_ff !== 3'(model_first()) || o_ffv !== 1'b1) begin
            failures++; $display("FAIL %s_first_fail got=%0d/%b want=%0d/1", nm, o_ff, o_ffv, model_first());
        end
        checks++;
        if (o_pass !== 1'b0 || dc !== 17) begin
            failures++; $display("FAIL %s_pass_done got pass=%b cycle=%0d want 0 17", nm, o_pass, dc);
        end
    endtask

    task automatic test_restart_in_done();
        sel = 1'b0; use_silly = 1'b1;
        run(0, dc, sq, e1, f1, d1);
        checks++;
        if (e1 !== 4'd0 || f1 !== 1'b0 || d1 !== 1'b0) begin
            failures++; $display("FAIL restart_clear got err=%0d ffv=%b done=%b want 0 0 0", e1, f1, d1);
        end
        checks++;
        if (o_pass !== 1'b1 || dc !== 17) begin
            failures++; $display("FAIL restart_pass got pass=%b cycle=%0d want 1 17", o_pass, dc);
        end
    endtask

    task automatic test_start_while_busy();
        sel = 1'b0; use_silly = 1'b1;
        run(5, dc, sq, e1, f1, d1);
        checks++;
        if (dc !== 17 || sq !== 1'b1 || o_pass !== 1'b1) begin
            failures++; $display("FAIL busy_start_ignored got cycle=%0d seq=%0d pass=%b want 17 1 1", dc, sq, o_pass);
        end
    endtask

    task automatic test_async_reset();
        sel = 1'b0; use_silly = 1'b0; tt = 8'h00;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({stim_a, busy_a, done_a, pass_a, err_a, ff_a, ffv_a} !== 14'd0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%b want=0", {stim_a, busy_a, done_a, pass_a, err_a, ff_a, ffv_a});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        use_silly = 1'b1;
        @(posedge clk); #1;
        run(0, dc, sq, e1, f1, d1);
        checks++;
        if (dc !== 17 || o_err !== 4'd0 || o_pass !== 1'b1) begin
            failures++; $display("FAIL after_reset_run got cycle=%0d err=%0d pass=%b want 17 0 1", dc, o_err, o_pass);
        end
    endtask

    task automatic test_random();
        int me, mf;
        sel = 1'b0; use_silly = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tt = 8'($urandom);
            if (i == 0) tt = GOLDEN;
            run(0, dc, sq, e1, f1, d1);
            me = model_errs(); mf = model_first();
            checks++;
            if (o_err !== 4'(me) || o_pass !== (me == 0) || dc !== 17) begin
                failures++; $display("FAIL random_err tt=%h got err=%0d pass=%b cycle=%0d want %0d %0d 17", tt, o_err, o_pass, dc, me, me == 0);
            end
            checks++;
            if (o_ffv !== (me != 0) || (me != 0 && o_ff !== 3'(mf))) begin
                failures++; $display("FAIL random_first tt=%h got ff=%0d ffv=%b want %0d %0d", tt, o_ff, o_ffv, mf, me != 0);
            end
        end
    endtask

    task automatic test_settle3();
        int me;
        sel = 1'b1; use_silly = 1'b1;
        run(0, dc, sq, e1, f1, d1);
        checks++;
        if (dc !== 33 || sq !== 1'b1 || o_pass !== 1'b1) begin
            failures++; $display("FAIL settle3_correct got cycle=%0d seq=%0d pass=%b want 33 1 1", dc, sq, o_pass);
        end
        use_silly = 1'b0; tt = 8'($urandom) | 8'h02;
        run(0, dc, sq, e1, f1, d1);
        me = model_errs();
        checks++;
        if (dc !== 33 || o_err !== 4'(me) || o_ff !== 3'(model_first()) || o_ffv !== (me != 0)) begin
            failures++; $display("FAIL settle3_random tt=%h got cycle=%0d err=%0d ff=%0d want 33 %0d %0d", tt, dc, o_err, o_ff, me, model_first());
        end
        sel = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_correct();
        test_stuck(1'b0, "stuck0");
        test_restart_in_done();
        test_stuck(1'b1, "stuck1");
        test_start_while_busy();
        test_async_reset();
        test_random();
        test_settle3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
